inst_seq_ctrl: RTL and testbench

Multi-cycle instruction sequencer for the RV64 core. It owns the PC and the instruction register, and steps each instruction through fetch, decode, execute, memory and write-back. It drives the instruction-fetch and data-memory request handshakes and gates the register-file write. It sits between the fetch interface and the decode/execute/memory datapath, and consumes decode flags to choose each instruction's path.

---
 rtl/inst_seq_ctrl.sv | 140 ++++++++++++++
 tb/tb_inst_seq_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_seq_ctrl.sv
// Multi-cycle RV64 instruction sequencer.
// Owns pc/inst and steps each instruction through F/D/E/M/WB.
module inst_seq_ctrl #(
    parameter logic [63:0] PC_RESET = 64'h0000_0000_8000_0000,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst,
    output logic        if_req,
    output logic [63:0] if_addr,
    input  logic        if_ready,
    input  logic [31:0] if_rdata,
    output logic [31:0] inst,
    output logic [63:0] pc,
    input  logic        dec_mem_to_reg,
    input  logic        dec_mem_w_ena,
    input  logic        dec_rd_w_ena,
    input  logic        dec_jump,
    input  logic [63:0] dec_jmp_imm,
    input  logic        dec_halt,
    input  logic        dec_illegal,
    output logic        ex_ena,
    output logic        mem_req,
    output logic        mem_we,
    input  logic        mem_ready,
    output logic        rd_w_pulse,
    output logic [63:0] retire_cnt,
    output logic        halted,
    output logic        error
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT,
        S_ERR
    } state_t;

    localparam logic [15:0] TO_LAST =
        (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);

    state_t      state;
    state_t      state_nx;
    logic [15:0] wait_cnt;
    logic [63:0] pc_nx;
    logic        misalign;
    logic        timed_out;
    logic        is_mem;

    assign pc_nx     = pc + (dec_jump ? dec_jmp_imm : 64'd4);
    assign misalign  = pc_nx[1:0] != 2'b00;
    assign is_mem    = dec_mem_to_reg | dec_mem_w_ena;
    // Expires in the TIMEOUT-th request cycle; a ready then still wins.
    assign timed_out = (TIMEOUT != 0) && (wait_cnt == TO_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_FETCH;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_FETCH: begin
                if (if_ready) state_nx = S_DECODE;
                else if (timed_out) state_nx = S_ERR;
            end
            S_DECODE: begin
                if (dec_illegal) state_nx = S_ERR;
                else if (dec_halt) state_nx = S_HALT;
                else state_nx = S_EXEC;
            end
            S_EXEC: state_nx = is_mem ? S_MEM : S_WB;
            S_MEM: begin
                if (mem_ready) state_nx = S_WB;
                else if (timed_out) state_nx = S_ERR;
            end
            S_WB: state_nx = misalign ? S_ERR : S_FETCH;
            S_HALT: state_nx = S_HALT;
            S_ERR: state_nx = S_ERR;
            default: state_nx = S_ERR;
        endcase
    end

    // Strobes are gated by rst so nothing is requested while in reset.
    always_comb begin
        if_req     = 1'b0;
        ex_ena     = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        rd_w_pulse = 1'b0;
        if (rst) begin
            unique case (state)
                S_FETCH: if_req = 1'b1;
                S_EXEC:  ex_ena = 1'b1;
                S_MEM: begin
                    mem_req = 1'b1;
                    mem_we  = dec_mem_w_ena;
                end
                S_WB: rd_w_pulse = dec_rd_w_ena & ~misalign;
                default: ;
            endcase
        end
    end

    assign if_addr = pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt   <= 16'd0;
            pc         <= PC_RESET;
            inst       <= 32'h0000_0013;
            retire_cnt <= 64'd0;
            halted     <= 1'b0;
            error      <= 1'b0;
        end else begin
            if (state_nx != state) begin
                wait_cnt <= 16'd0;
            end else if (state == S_FETCH || state == S_MEM) begin
                wait_cnt <= wait_cnt + 16'd1;
            end
            if (state == S_FETCH && if_ready) begin
                inst <= if_rdata;
            end
            if (state == S_WB && !misalign) begin
                pc         <= pc_nx;
                retire_cnt <= retire_cnt + 64'd1;
            end
            if (state_nx == S_HALT) halted <= 1'b1;
            if (state_nx == S_ERR) error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_inst_seq_ctrl.sv
// Randomized scoreboard bench for inst_seq_ctrl.
// Episodes of random instructions, each ending in a terminal event.
module tb_inst_seq_ctrl;

    localparam logic [63:0] PC_RST = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req;
    logic [63:0] if_addr;
    logic        if_ready = 1'b0;
    logic [31:0] if_rdata = 32'd0;
    logic [31:0] inst;
    logic [63:0] pc;
    logic        dec_mem_to_reg = 1'b0;
    logic        dec_mem_w_ena = 1'b0;
    logic        dec_rd_w_ena = 1'b0;
    logic        dec_jump = 1'b0;
    logic [63:0] dec_jmp_imm = 64'd0;
    logic        dec_halt = 1'b0;
    logic        dec_illegal = 1'b0;
    logic        ex_ena;
    logic        mem_req;
    logic        mem_we;
    logic        mem_ready = 1'b0;
    logic        rd_w_pulse;
    logic [63:0] retire_cnt;
    logic        halted;
    logic        error;

    inst_seq_ctrl #(
        .PC_RESET(PC_RST),
        .TIMEOUT (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .if_req        (if_req),
        .if_addr       (if_addr),
        .if_ready      (if_ready),
        .if_rdata      (if_rdata),
        .inst          (inst),
        .pc            (pc),
        .dec_mem_to_reg(dec_mem_to_reg),
        .dec_mem_w_ena (dec_mem_w_ena),
        .dec_rd_w_ena  (dec_rd_w_ena),
        .dec_jump      (dec_jump),
        .dec_jmp_imm   (dec_jmp_imm),
        .dec_halt      (dec_halt),
        .dec_illegal   (dec_illegal),
        .ex_ena        (ex_ena),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_ready     (mem_ready),
        .rd_w_pulse    (rd_w_pulse),
        .retire_cnt    (retire_cnt),
        .halted        (halted),
        .error         (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic [63:0] pc_next;
        logic [63:0] ret;
        logic [31:0] inst;
        int          lat;
        int          rdw;
    } exp_t;

    exp_t        q[$];
    int          compared = 0;
    int          mismatched = 0;
    logic [63:0] mpc;
    logic [63:0] mret;
    logic [63:0] last_ret;
    int          cyc;
    int          pulses;
    int          memw_bad;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: retirements first, then fetch addresses.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            last_ret = 64'd0;
            cyc      = 0;
            pulses   = 0;
        end else begin
            chk("req_excl", 64'(if_req & mem_req), 64'd0);
            if (rd_w_pulse) pulses++;
            if (mem_req && mem_we !== dec_mem_w_ena) memw_bad++;
            if (retire_cnt !== last_ret) begin
                if (q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL retire_unexp: got %h expected none",
                             retire_cnt);
                end else begin
                    e = q.pop_front();
                    chk("ret_pc", pc, e.pc_next);
                    chk("ret_cnt", retire_cnt, e.ret);
                    chk("ret_inst", 64'(inst), 64'(e.inst));
                    chk("ret_lat", 64'(cyc), 64'(e.lat));
                    chk("ret_rdw", 64'(pulses), 64'(e.rdw));
                end
                last_ret = retire_cnt;
                cyc      = 1;
                pulses   = 0;
            end else begin
                cyc++;
            end
            if (if_req && if_ready && q.size() > 0) begin
                chk("fetch_addr", if_addr, q[0].pc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input bit mem);
        for (int i = 0; i < 50; i++) begin
            if (mem ? mem_req : if_req) return;
            tick();
        end
        compared++;
        mismatched++;
        $display("FAIL wait_req: got no request expected mem=%0d", mem);
    endtask

    task automatic set_dec(input int kind, input logic [63:0] imm,
                           input bit rdw, input bit hlt, input bit ill);
        dec_mem_to_reg = (kind == 1);
        dec_mem_w_ena  = (kind == 2);
        dec_jump       = (kind == 3);
        dec_jmp_imm    = imm;
        dec_rd_w_ena   = rdw;
        dec_halt       = hlt;
        dec_illegal    = ill;
    endtask

    task automatic fetch(input int fw, input logic [31:0] d);
        wait_req(0);
        if_ready = 1'b0;
        repeat (fw) tick();
        if_ready = 1'b1;
        if_rdata = d;
        tick();
        if_ready = 1'b0;
    endtask

    // kind: 0 alu, 1 load, 2 store, 3 jump
    task automatic run_inst(input int kind, input int fw, input int mw,
                            input logic [63:0] imm, input bit rdw);
        exp_t        e;
        logic [31:0] d;
        bit          mem;
        d   = $urandom;
        mem = (kind == 1 || kind == 2);
        wait_req(0);
        e.pc      = mpc;
        e.inst    = d;
        e.lat     = fw + 4 + (mem ? mw + 1 : 0);
        e.rdw     = rdw ? 1 : 0;
        e.pc_next = (kind == 3) ? mpc + imm : mpc + 64'd4;
        e.ret     = mret + 64'd1;
        q.push_back(e);
        mpc  = e.pc_next;
        mret = e.ret;
        set_dec(kind, imm, rdw, 1'b0, 1'b0);
        fetch(fw, d);
        if (mem) begin
            wait_req(1);
            repeat (mw) tick();
            mem_ready = 1'b1;
            tick();
            mem_ready = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst      = 1'b0;
        if_ready = 1'b0;
        mem_ready = 1'b0;
        set_dec(0, 64'd0, 1'b0, 1'b0, 1'b0);
        q.delete();
        repeat (2) tick();
        chk("rst_pc", pc, PC_RST);
        chk("rst_inst", 64'(inst), 64'h13);
        chk("rst_ret", retire_cnt, 64'd0);
        chk("rst_flags", 64'({halted, error}), 64'd0);
        chk("rst_strobes",
            64'({if_req, ex_ena, mem_req, mem_we, rd_w_pulse}), 64'd0);
        rst  = 1'b1;
        mpc  = PC_RST;
        mret = 64'd0;
        #1;
        chk("first_if_req", 64'(if_req), 64'd1);
    endtask

    task automatic check_end(input bit h, input bit er);
        chk("end_halted", 64'(halted), 64'(h));
        chk("end_error", 64'(error), 64'(er));
        chk("end_reqs", 64'({if_req, mem_req, ex_ena}), 64'd0);
        chk("end_pc", pc, mpc);
        chk("end_ret", retire_cnt, mret);
        chk("end_pulses", 64'(pulses), 64'd0);
    endtask

    initial begin
        int          kind;
        int          n;
        logic [63:0] imm;
        memw_bad = 0;
        for (int ep = 0; ep < 12; ep++) begin
            do_reset();
            n = $urandom_range(3, 8);
            for (int k = 0; k < n; k++) begin
                kind = $urandom_range(0, 3);
                imm  = (kind == 3)
                     ? (64'($urandom_range(0, 40)) - 64'd20) << 2
                     : {32'($urandom), 32'($urandom)};
                run_inst(kind, $urandom_range(0, 3),
                         $urandom_range(0, 3), imm,
                         (kind == 2) ? 1'b0 : 1'($urandom));
            end
            case (ep % 6)
                0, 1: begin
                    wait_req(0);
                    set_dec(0, 64'd0, 1'b1, 1'b1, ep % 6 == 1);
                    fetch($urandom_range(0, 3), 32'h0010_0073);
                    repeat (3) tick();
                    check_end(ep % 6 == 0, ep % 6 == 1);
                end
                2: begin
                    wait_req(0);
                    imm = (64'($urandom_range(0, 8)) << 2)
                        + 64'($urandom_range(1, 3));
                    set_dec(3, imm, 1'b1, 1'b0, 1'b0);
                    fetch(0, $urandom);
                    repeat (4) tick();
                    check_end(1'b0, 1'b1);
                end
                3: begin
                    wait_req(0);
                    repeat (3) tick();
                    chk("to_if_hold", 64'({if_req, error}), 64'b10);
                    tick();
                    check_end(1'b0, 1'b1);
                end
                4: begin
                    wait_req(0);
                    set_dec(1, 64'd0, 1'b1, 1'b0, 1'b0);
                    fetch(0, $urandom);
                    wait_req(1);
                    repeat (3) tick();
                    chk("to_mem_hold", 64'({mem_req, error}), 64'b10);
                    tick();
                    check_end(1'b0, 1'b1);
                end
                default: begin
                    wait_req(0);
                    set_dec(2, 64'd0, 1'b0, 1'b0, 1'b0);
                    fetch(0, $urandom);
                    wait_req(1);
                    repeat ($urandom_range(0, 2)) tick();
                    chk("pre_rst_memreq", 64'(mem_req), 64'd1);
                    rst = 1'b0;
                    #1;
                    chk("rst_mem_req", 64'(mem_req), 64'd0);
                    chk("rst_mem_pc", pc, PC_RST);
                    chk("rst_mem_ret", retire_cnt, 64'd0);
                end
            endcase
        end
        chk("mem_we_track", 64'(memw_bad), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
